// File: rtl/ftoi_pkg.sv
// Shared FPU constants, the S1 stage record, and the S1 decode helper
// for the float-to-int pipeline.
package ftoi_pkg;

  localparam int unsigned XW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 24;

  localparam logic [EW-1:0] EXP_BIAS    = 8'd127;
  localparam logic [EW-1:0] EXP_LO      = EXP_BIAS - 8'd1;
  localparam logic [EW-1:0] EXP_HI      = EXP_BIAS + 8'd31;
  localparam logic [EW-1:0] EXP_SPECIAL = 8'hFF;

  localparam logic [XW-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [XW-1:0] SAT_NEG = 32'h8000_0000;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] man;
    logic          zero_small;
    logic          sat;
  } s1_t;

  // Split the operand and classify it by exponent range.
  function automatic s1_t decode(input logic [XW-1:0] x);
    s1_t d;
    d.sign       = x[31];
    d.exp        = x[30:23];
    d.man        = {(x[30:23] != 8'd0), x[22:0]};
    d.zero_small = (x[30:23] < EXP_LO);
    d.sat        = (x[30:23] >= EXP_HI);
    return d;
  endfunction

endpackage

// File: rtl/ftoi_core.sv
// Combinational S2 logic: align, round half away from zero, apply sign,
// and saturate out-of-range, Inf and NaN operands.
module ftoi_core
  import ftoi_pkg::*;
(
  input  s1_t           i_s1,
  output logic [XW-1:0] o_res_c,
  output logic          o_ovf_c
);

  logic [5:0]    w_sh;
  logic [XW:0]   w_t;
  logic [XW-1:0] w_mag;
  logic          w_exact_min;

  // Shift is 1..32 for every in-range exponent; other values are don't-care.
  assign w_sh  = 6'(EXP_HI - i_s1.exp);
  assign w_t   = {i_s1.man, 9'b0} >> w_sh;
  assign w_mag = w_t[XW:1] + XW'(w_t[0]);

  // -2^31 is representable, so it is the one exp=158 value that is not an overflow.
  assign w_exact_min = i_s1.sign && (i_s1.exp == EXP_HI) && (i_s1.man == 24'h80_0000);

  always_comb begin
    o_res_c = '0;
    o_ovf_c = 1'b0;
    if (i_s1.sat) begin
      if (i_s1.exp == EXP_SPECIAL) begin
        o_res_c = SAT_POS;
        o_ovf_c = 1'b1;
      end else if (w_exact_min) begin
        o_res_c = SAT_NEG;
      end else begin
        o_res_c = i_s1.sign ? SAT_NEG : SAT_POS;
        o_ovf_c = 1'b1;
      end
    end else if (!i_s1.zero_small) begin
      o_res_c = i_s1.sign ? (~w_mag + 32'd1) : w_mag;
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float32 to int32 converter with valid/ready handshaking on
// both sides; S1 decodes, S2 holds the converted result on the outputs.
module ftoi_pipe
  import ftoi_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_res,
  output logic          out_ovf
);

  logic          r_s1_valid;
  s1_t           r_s1;
  logic          r_out_valid;
  logic [XW-1:0] r_out_res;
  logic          r_out_ovf;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic [XW-1:0] w_res;
  logic          w_ovf;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  ftoi_core u_core (
    .i_s1    (r_s1),
    .o_res_c (w_res),
    .o_ovf_c (w_ovf)
  );

  // Stage valid bits and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_res <= w_res;
          r_out_ovf <= w_ovf;
        end
      end
    end
  end

  // S1 payload is qualified by r_s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s1 <= decode(in_x);
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed and randomized bench for ftoi_pipe with an in-order scoreboard
// of {ovf, res} expectations.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic        out_ovf;

  always #5 clk = ~clk;

  ftoi_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_pop  = 0;
  logic [32:0] expq[$];
  logic        s_ir, s_ov;
  logic [32:0] s_out;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: value = mant24 * 2^(exp-150), rounded half away from zero.
  function automatic logic [32:0] model(input logic [31:0] x);
    logic        s;
    int          e;
    longint      m, mag;
    logic [31:0] r;
    s = x[31];
    e = int'(x[30:23]);
    m = longint'({1'b1, x[22:0]});
    if (e == 255) return {1'b1, 32'h7FFF_FFFF};
    if (x == 32'hCF00_0000) return {1'b0, 32'h8000_0000};
    if (e >= 158) return s ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    if (e < 126) return 33'd0;
    if (e >= 150) mag = m << (e - 150);
    else mag = (m >> (150 - e)) + ((m >> (149 - e)) & 64'sd1);
    r = s ? 32'(-mag) : 32'(mag);
    return {1'b0, r};
  endfunction

  // One cycle: drive, sample just before the edge, score both ports.
  task automatic step(input logic v, input logic [31:0] x, input logic [32:0] e,
                      input logic ordy, output logic acc);
    in_valid  = v;
    in_x      = x;
    out_ready = ordy;
    #7;
    acc   = v && in_ready;
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_out = {out_ovf, out_res};
    if (out_valid && out_ready) begin
      n_pop++;
      if (expq.size() == 0) chk("spurious_result", 33'(expq.size()), 33'd1);
      else chk("result", {out_ovf, out_res}, expq.pop_front());
    end
    if (acc) expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 12 && expq.size() != 0; i++) step(1'b0, 32'h0, 33'h0, 1'b1, a);
    chk("drain_empty", 33'(expq.size()), 33'd0);
  endtask

  initial begin
    logic        acc;
    int          p0, nacc, idx;
    logic [31:0] rv[5], lv[4], bv[5], x;
    logic [32:0] re[5], le[4], be[5];

    rv = '{32'h3F80_0000, 32'h3FC0_0000, 32'hBFC0_0000, 32'h3F00_0000, 32'h3EFF_FFFF};
    re = '{33'h0_0000_0001, 33'h0_0000_0002, 33'h0_FFFF_FFFE, 33'h0_0000_0001, 33'h0_0000_0000};
    lv = '{32'h4EFF_FFFF, 32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001};
    le = '{33'h0_7FFF_FF80, 33'h1_7FFF_FFFF, 33'h0_8000_0000, 33'h1_8000_0000};
    bv = '{32'h7F80_0000, 32'hFFC0_0000, 32'h8000_0000, 32'h0000_0001, 32'h4EFF_FFFF};
    be = '{33'h1_7FFF_FFFF, 33'h1_7FFF_FFFF, 33'h0_0000_0000, 33'h0_0000_0000, 33'h0_7FFF_FF80};

    // Reset state
    #12;
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out", {out_ovf, out_res}, 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Rounding burst: 2-cycle latency, one result per cycle
    p0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rv[i], re[i], 1'b1, acc);
      chk("burst_accept", 33'(acc), 33'd1);
      if (i == 1) chk("latency_none_yet", 33'(n_pop - p0), 33'd0);
      if (i == 2) chk("latency_first", 33'(n_pop - p0), 33'd1);
    end
    step(1'b0, 32'h0, 33'h0, 1'b1, acc);
    step(1'b0, 32'h0, 33'h0, 1'b1, acc);
    chk("throughput", 33'(n_pop - p0), 33'd5);
    drain();

    // Range limits
    for (int i = 0; i < 4; i++) step(1'b1, lv[i], le[i], 1'b1, acc);
    drain();

    // Backpressure with specials
    nacc = 0;
    idx  = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, bv[idx], be[idx], 1'b0, acc);
      if (acc) begin nacc++; idx++; end
      if (c >= 2) begin
        chk("bp_in_ready_low", 33'(s_ir), 33'd0);
        chk("bp_out_valid", 33'(s_ov), 33'd1);
        chk("bp_hold", s_out, be[0]);
      end
    end
    chk("bp_accepts", 33'(nacc), 33'd2);
    for (int c = 0; c < 20 && idx < 5; c++) begin
      step(1'b1, bv[idx], be[idx], 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", 33'(idx), 33'd5);
    drain();

    // Reset with both stages full
    step(1'b1, 32'h3F80_0000, 33'h1, 1'b0, acc);
    step(1'b1, 32'h4000_0000, 33'h2, 1'b0, acc);
    chk("pre_rst_full", 33'(out_valid), 33'd1);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_async_out_valid", 33'(out_valid), 33'd0);
    chk("rst_async_in_ready", 33'(in_ready), 33'd1);
    expq.delete();
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    p0 = n_pop;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 33'h0, 1'b1, acc);
    chk("no_stale_result", 33'(n_pop - p0), 33'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(120, 160));
      step(1'($urandom_range(0, 1)), x, model(x), ($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
